// File: rtl/get_order_pkg.sv
// Register map, bit positions and field widths shared by the
// get_order AXI-Lite slave and its handshake front end.
package get_order_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned IDX_W  = 6;

    localparam logic [ADDR_W-1:0] OFF_CMD      = 8'h00;
    localparam logic [ADDR_W-1:0] OFF_STATUS   = 8'h04;
    localparam logic [ADDR_W-1:0] OFF_CTRL     = 8'h08;
    localparam logic [ADDR_W-1:0] OFF_FI_BASE  = 8'h0C;
    localparam logic [ADDR_W-1:0] OFF_IO_PATCH = 8'h10;
    localparam logic [ADDR_W-1:0] OFF_PATCH    = 8'h14;
    localparam logic [ADDR_W-1:0] OFF_SIZE     = 8'h18;
    localparam logic [ADDR_W-1:0] OFF_QUANT    = 8'h1C;
    localparam logic [ADDR_W-1:0] OFF_RET_ADDR = 8'h20;
    localparam logic [ADDR_W-1:0] OFF_WLEN     = 8'h24;

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] off);
        return off[ADDR_W-1:2];
    endfunction

    localparam logic [IDX_W-1:0] IDX_CMD    = idx_of(OFF_CMD);
    localparam logic [IDX_W-1:0] IDX_STATUS = idx_of(OFF_STATUS);
    localparam logic [IDX_W-1:0] IDX_CTRL   = idx_of(OFF_CTRL);
    localparam logic [IDX_W-1:0] IDX_WLEN   = idx_of(OFF_WLEN);

    // Parameter words are stored contiguously from OFF_CTRL.
    localparam int NUM_PARAM  = 8;
    localparam int P_CTRL     = 0;
    localparam int P_FI_BASE  = 1;
    localparam int P_IO_PATCH = 2;
    localparam int P_PATCH    = 3;
    localparam int P_SIZE     = 4;
    localparam int P_QUANT    = 5;
    localparam int P_RET_ADDR = 6;
    localparam int P_WLEN     = 7;

    localparam logic [NUM_PARAM-1:0][DATA_W-1:0] PARAM_MASK = {
        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h001F_1F1F, 32'hFFFF_FFFF,
        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h00FF_333F
    };

    localparam int CMD_W           = 3;
    localparam int CMD_TASK_START  = 0;
    localparam int CMD_CALC_START  = 1;
    localparam int CMD_TASK_FINISH = 2;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;

    localparam int ORDER_W = 4;
    localparam int STRIDE_W = 2;
    localparam int PAD_W   = 2;
    localparam int ID_W    = 8;
    localparam int HALF_W  = 16;
    localparam int QUANT_W = 5;

endpackage

// File: rtl/get_order_axil_if.sv
// AXI4-Lite handshake front end: single-beat write/read acceptance,
// held B/R responses, and a simple register-file side interface.
module get_order_axil_if
    import get_order_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] awaddr_i,
    input  logic [2:0]        awprot_i,
    input  logic              awvalid_i,
    output logic              awready_o,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [3:0]        wstrb_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    output logic [1:0]        bresp_o,
    output logic              bvalid_o,
    input  logic              bready_i,
    input  logic [ADDR_W-1:0] araddr_i,
    input  logic [2:0]        arprot_i,
    input  logic              arvalid_i,
    output logic              arready_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        rresp_o,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic              wr_en_o,
    output logic [IDX_W-1:0]  wr_idx_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [3:0]        wstrb_o,
    output logic              rd_en_o,
    output logic [IDX_W-1:0]  rd_idx_o,
    input  logic [DATA_W-1:0] rd_data_i
);

    logic              awready_q, awready_d;
    logic              bvalid_q, bvalid_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              aw_acc, ar_acc;
    logic              unused_bits;

    always_comb begin
        aw_acc    = awready_q & awvalid_i & wvalid_i;
        ar_acc    = arready_q & arvalid_i;
        // Ready is a one-cycle pulse; the !ready term stops a second accept.
        awready_d = awvalid_i & wvalid_i & ~bvalid_q & ~awready_q;
        arready_d = arvalid_i & ~rvalid_q & ~arready_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        if (bvalid_q && bready_i) bvalid_d = 1'b0;
        if (aw_acc) bvalid_d = 1'b1;
        if (rvalid_q && rready_i) rvalid_d = 1'b0;
        if (ar_acc) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign awready_o = awready_q;
    assign wready_o  = awready_q;
    assign bresp_o   = 2'b00;
    assign bvalid_o  = bvalid_q;
    assign arready_o = arready_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = 2'b00;
    assign rvalid_o  = rvalid_q;

    assign wr_en_o  = aw_acc;
    assign wr_idx_o = awaddr_i[ADDR_W-1:2];
    assign wdata_o  = wdata_i;
    assign wstrb_o  = wstrb_i;
    assign rd_en_o  = ar_acc;
    assign rd_idx_o = araddr_i[ADDR_W-1:2];

    assign unused_bits = ^{awprot_i, arprot_i, awaddr_i[1:0], araddr_i[1:0]};

endmodule

// File: rtl/get_order_axil.sv
// Accelerator command/parameter register file on AXI4-Lite.
// Define ORDER_READBACK_EN to make the parameter words 0x08-0x24 readable.
module get_order_axil
    import get_order_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic                            task_start,
    output logic                            calculate_start,
    output logic                            task_finish,
    input  logic                            calculate_finish,
    output logic [3:0]                      order,
    output logic                            activate,
    output logic                            feature_double_patch,
    output logic [1:0]                      stride,
    output logic [1:0]                      padding_size,
    output logic [7:0]                      id,
    output logic [31:0]                     feature_input_base_addr,
    output logic [31:0]                     return_addr,
    output logic [31:0]                     weight_data_length,
    output logic [15:0]                     feature_input_patch_num,
    output logic [15:0]                     feature_output_patch_num,
    output logic [15:0]                     feature_patch_num,
    output logic [15:0]                     return_patch_num,
    output logic [15:0]                     row_size,
    output logic [15:0]                     col_size,
    output logic [4:0]                      weight_quant_size,
    output logic [4:0]                      fea_in_quant_size,
    output logic [4:0]                      fea_out_quant_size
);

    logic                                wr_en, rd_en;
    logic [IDX_W-1:0]                    wr_idx, rd_idx;
    logic [DATA_W-1:0]                   wdata, rd_data;
    logic [3:0]                          wstrb;
    logic [NUM_PARAM-1:0][DATA_W-1:0]    param_q, param_d;
    logic [CMD_W-1:0]                    cmd_q, cmd_d;
    logic                                busy_q, busy_d;
    logic                                done_q, done_d;
    logic                                unused_bits;

    get_order_axil_if u_if (
        .clk_i     (s00_axi_aclk),
        .rst_i     (s00_axi_areset),
        .awaddr_i  (s00_axi_awaddr),
        .awprot_i  (s00_axi_awprot),
        .awvalid_i (s00_axi_awvalid),
        .awready_o (s00_axi_awready),
        .wdata_i   (s00_axi_wdata),
        .wstrb_i   (s00_axi_wstrb),
        .wvalid_i  (s00_axi_wvalid),
        .wready_o  (s00_axi_wready),
        .bresp_o   (s00_axi_bresp),
        .bvalid_o  (s00_axi_bvalid),
        .bready_i  (s00_axi_bready),
        .araddr_i  (s00_axi_araddr),
        .arprot_i  (s00_axi_arprot),
        .arvalid_i (s00_axi_arvalid),
        .arready_o (s00_axi_arready),
        .rdata_o   (s00_axi_rdata),
        .rresp_o   (s00_axi_rresp),
        .rvalid_o  (s00_axi_rvalid),
        .rready_i  (s00_axi_rready),
        .wr_en_o   (wr_en),
        .wr_idx_o  (wr_idx),
        .wdata_o   (wdata),
        .wstrb_o   (wstrb),
        .rd_en_o   (rd_en),
        .rd_idx_o  (rd_idx),
        .rd_data_i (rd_data)
    );

    always_comb begin
        param_d = param_q;
        for (int p = 0; p < NUM_PARAM; p++) begin
            if (wr_en && wr_idx == IDX_CTRL + IDX_W'(p)) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[b]) begin
                        param_d[p][8*b +: 8] = wdata[8*b +: 8] & PARAM_MASK[p][8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        cmd_d = '0;
        if (wr_en && wr_idx == IDX_CMD && wstrb[0]) begin
            cmd_d = wdata[CMD_W-1:0];
        end
    end

    // A fresh start outranks a finish seen in the same cycle.
    always_comb begin
        busy_d = busy_q;
        done_d = done_q;
        if (cmd_q[CMD_CALC_START]) begin
            busy_d = 1'b1;
            done_d = 1'b0;
        end else if (busy_q && calculate_finish) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_idx == IDX_STATUS) begin
            rd_data[ST_BUSY] = busy_q;
            rd_data[ST_DONE] = done_q;
        end
`ifdef ORDER_READBACK_EN
        else if (rd_idx >= IDX_CTRL && rd_idx <= IDX_WLEN) begin
            rd_data = param_q[3'(rd_idx - IDX_CTRL)];
        end
`endif
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            param_q <= '0;
            cmd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            param_q <= param_d;
            cmd_q   <= cmd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign task_start      = cmd_q[CMD_TASK_START];
    assign calculate_start = cmd_q[CMD_CALC_START];
    assign task_finish     = cmd_q[CMD_TASK_FINISH];

    assign order                    = param_q[P_CTRL][ORDER_W-1:0];
    assign activate                 = param_q[P_CTRL][4];
    assign feature_double_patch     = param_q[P_CTRL][5];
    assign stride                   = param_q[P_CTRL][8 +: STRIDE_W];
    assign padding_size             = param_q[P_CTRL][12 +: PAD_W];
    assign id                       = param_q[P_CTRL][16 +: ID_W];
    assign feature_input_base_addr  = param_q[P_FI_BASE];
    assign feature_input_patch_num  = param_q[P_IO_PATCH][0 +: HALF_W];
    assign feature_output_patch_num = param_q[P_IO_PATCH][HALF_W +: HALF_W];
    assign feature_patch_num        = param_q[P_PATCH][0 +: HALF_W];
    assign return_patch_num         = param_q[P_PATCH][HALF_W +: HALF_W];
    assign row_size                 = param_q[P_SIZE][0 +: HALF_W];
    assign col_size                 = param_q[P_SIZE][HALF_W +: HALF_W];
    assign weight_quant_size        = param_q[P_QUANT][0 +: QUANT_W];
    assign fea_in_quant_size        = param_q[P_QUANT][8 +: QUANT_W];
    assign fea_out_quant_size       = param_q[P_QUANT][16 +: QUANT_W];
    assign return_addr              = param_q[P_RET_ADDR];
    assign weight_data_length       = param_q[P_WLEN];

    assign unused_bits = ^{rd_en,
                           param_q[P_CTRL][31:24], param_q[P_CTRL][15:14],
                           param_q[P_CTRL][11:10], param_q[P_CTRL][7:6],
                           param_q[P_QUANT][31:21], param_q[P_QUANT][15:13],
                           param_q[P_QUANT][7:5]};

endmodule

// File: tb/tb_get_order_axil.sv
// Directed self-checking bench for get_order_axil.
module tb_get_order_axil;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        task_start, calculate_start, task_finish;
    logic        calculate_finish = 0;
    logic [3:0]  order;
    logic        activate, feature_double_patch;
    logic [1:0]  stride, padding_size;
    logic [7:0]  id;
    logic [31:0] fi_base, ret_addr, wlen;
    logic [15:0] fi_pn, fo_pn, f_pn, r_pn, row_size, col_size;
    logic [4:0]  wq, fiq, foq;

    int n_checks = 0;
    int n_fail = 0;
    int ts_cnt = 0, cs_cnt = 0, tf_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (task_start) ts_cnt++;
        if (calculate_start) cs_cnt++;
        if (task_finish) tf_cnt++;
    end

    get_order_axil dut (
        .s00_axi_aclk(clk), .s00_axi_areset(rst),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot),
        .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot),
        .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
        .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .task_start(task_start), .calculate_start(calculate_start),
        .task_finish(task_finish), .calculate_finish(calculate_finish),
        .order(order), .activate(activate),
        .feature_double_patch(feature_double_patch),
        .stride(stride), .padding_size(padding_size), .id(id),
        .feature_input_base_addr(fi_base), .return_addr(ret_addr),
        .weight_data_length(wlen),
        .feature_input_patch_num(fi_pn), .feature_output_patch_num(fo_pn),
        .feature_patch_num(f_pn), .return_patch_num(r_pn),
        .row_size(row_size), .col_size(col_size),
        .weight_quant_size(wq), .fea_in_quant_size(fiq),
        .fea_out_quant_size(foq)
    );

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp,
                             output bit ok);
        int n;
        ok = 1;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1; wvalid = 1;
        n = 0;
        while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) ok = 0;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) ok = 0;
        resp = bresp;
        bready = 1;
        @(negedge clk);
        bready = 0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d,
                            output logic [1:0] resp, output bit ok);
        int n;
        ok = 1;
        araddr = a; arvalid = 1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) ok = 0;
        @(negedge clk);
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) ok = 0;
        d = rdata; resp = rresp;
        rready = 1;
        @(negedge clk);
        rready = 0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic [1:0]  r;
        bit ok;
        rst = 1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: got %b want 00000",
                     {awready, wready, bvalid, arready, rvalid});
        end
        n_checks++;
        if ({bresp, rresp, rdata} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_resp: bresp=%b rresp=%b rdata=%h want 0", bresp, rresp, rdata);
        end
        n_checks++;
        if ({task_start, calculate_start, task_finish, order, activate,
             feature_double_patch, stride, padding_size, id, fi_base, ret_addr,
             wlen, fi_pn, fo_pn, f_pn, r_pn, row_size, col_size, wq, fiq, foq} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: some control output nonzero, want all 0");
        end
        rst = 0;
        @(negedge clk);
        axi_read(8'h04, d, r, ok);
        n_checks++;
        if (!ok || d !== 32'h0 || r !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_status: ok=%0d rdata=%h rresp=%b want 0", ok, d, r);
        end
        axi_read(8'h08, d, r, ok);
        n_checks++;
        if (!ok || d !== 32'h0 || r !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ctrl_read: ok=%0d rdata=%h rresp=%b want 0", ok, d, r);
        end
    endtask

    task automatic test_strobe;
        logic [31:0] d, exp_rd;
        logic [1:0]  r;
        bit ok;
        axi_write(8'h0C, 32'h1234_5678, 4'b0011, r, ok);
        n_checks++;
        if (!ok || r !== 2'b00 || fi_base !== 32'h0000_5678) begin
            n_fail++;
            $display("FAIL strobe_write: ok=%0d bresp=%b fi_base=%h want 00005678", ok, r, fi_base);
        end
`ifdef ORDER_READBACK_EN
        exp_rd = 32'h0000_5678;
`else
        exp_rd = 32'h0;
`endif
        axi_read(8'h0C, d, r, ok);
        n_checks++;
        if (!ok || d !== exp_rd) begin
            n_fail++;
            $display("FAIL strobe_readback: ok=%0d rdata=%h want %h", ok, d, exp_rd);
        end
    endtask

    task automatic test_ctrl;
        logic [1:0] r;
        bit ok;
        axi_write(8'h08, 32'h0005_3213, 4'hF, r, ok);
        n_checks++;
        if (!ok || {order, activate, feature_double_patch} !== {4'd3, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL ctrl_low: ok=%0d order=%0d act=%b fdp=%b want 3 1 0",
                     ok, order, activate, feature_double_patch);
        end
        n_checks++;
        if ({stride, padding_size, id} !== {2'd2, 2'd3, 8'd5}) begin
            n_fail++;
            $display("FAIL ctrl_high: stride=%0d pad=%0d id=%0d want 2 3 5",
                     stride, padding_size, id);
        end
    endtask

    task automatic test_params;
        logic [31:0] d;
        logic [1:0]  r;
        bit ok, all_ok;
        all_ok = 1;
        axi_write(8'h10, 32'hAAAA_5555, 4'hF, r, ok); all_ok &= ok;
        axi_write(8'h14, 32'h0002_0001, 4'hF, r, ok); all_ok &= ok;
        axi_write(8'h18, 32'h00E0_00F0, 4'hF, r, ok); all_ok &= ok;
        axi_write(8'h1C, 32'hFFFF_FFFF, 4'hF, r, ok); all_ok &= ok;
        axi_write(8'h20, 32'h8000_0004, 4'hF, r, ok); all_ok &= ok;
        axi_write(8'h24, 32'hDEAD_BEEF, 4'hF, r, ok); all_ok &= ok;
        n_checks++;
        if (!all_ok || {fi_pn, fo_pn, f_pn, r_pn} !== {16'h5555, 16'hAAAA, 16'h0001, 16'h0002}) begin
            n_fail++;
            $display("FAIL patch_nums: ok=%0d got %h %h %h %h want 5555 aaaa 0001 0002",
                     all_ok, fi_pn, fo_pn, f_pn, r_pn);
        end
        n_checks++;
        if ({row_size, col_size} !== {16'h00F0, 16'h00E0}) begin
            n_fail++;
            $display("FAIL sizes: row=%h col=%h want 00f0 00e0", row_size, col_size);
        end
        n_checks++;
        if ({wq, fiq, foq} !== {5'h1F, 5'h1F, 5'h1F}) begin
            n_fail++;
            $display("FAIL quant: %h %h %h want 1f 1f 1f", wq, fiq, foq);
        end
        n_checks++;
        if (ret_addr !== 32'h8000_0004 || wlen !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL addr_len: ret=%h wlen=%h want 80000004 deadbeef", ret_addr, wlen);
        end
        axi_write(8'hF0, 32'hFFFF_FFFF, 4'hF, r, ok);
        n_checks++;
        if (!ok || r !== 2'b00 || fi_base !== 32'h0000_5678 || order !== 4'd3 ||
            wlen !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL unmapped_write: ok=%0d bresp=%b fi_base=%h order=%0d wlen=%h",
                     ok, r, fi_base, order, wlen);
        end
`ifdef ORDER_READBACK_EN
        axi_read(8'h1C, d, r, ok);
        n_checks++;
        if (!ok || d !== 32'h001F_1F1F) begin
            n_fail++;
            $display("FAIL quant_readback: rdata=%h want 001f1f1f", d);
        end
        axi_read(8'h08, d, r, ok);
        n_checks++;
        if (!ok || d !== 32'h0005_3213) begin
            n_fail++;
            $display("FAIL ctrl_readback: rdata=%h want 00053213", d);
        end
`else
        axi_read(8'h24, d, r, ok);
        n_checks++;
        if (!ok || d !== 32'h0) begin
            n_fail++;
            $display("FAIL wlen_hidden: rdata=%h want 0", d);
        end
`endif
    endtask

    task automatic test_calc;
        logic [31:0] d;
        logic [1:0]  r;
        bit ok;
        int cs0, ts0, tf0;
        calculate_finish = 0;
        cs0 = cs_cnt; ts0 = ts_cnt; tf0 = tf_cnt;
        axi_write(8'h00, 32'h2, 4'hF, r, ok);
        repeat (3) @(negedge clk);
        n_checks++;
        if (!ok || cs_cnt - cs0 != 1 || ts_cnt != ts0 || tf_cnt != tf0) begin
            n_fail++;
            $display("FAIL calc_pulse: cs=%0d ts=%0d tf=%0d want 1 0 0",
                     cs_cnt - cs0, ts_cnt - ts0, tf_cnt - tf0);
        end
        axi_read(8'h04, d, r, ok);
        n_checks++;
        if (!ok || d !== 32'h1) begin
            n_fail++;
            $display("FAIL status_busy: rdata=%h want 1", d);
        end
        axi_read(8'h00, d, r, ok);
        n_checks++;
        if (!ok || d !== 32'h0) begin
            n_fail++;
            $display("FAIL cmd_read: rdata=%h want 0", d);
        end
        calculate_finish = 1;
        @(negedge clk);
        calculate_finish = 0;
        axi_read(8'h04, d, r, ok);
        n_checks++;
        if (!ok || d !== 32'h2) begin
            n_fail++;
            $display("FAIL status_done: rdata=%h want 2", d);
        end
    endtask

    task automatic test_finish_tied;
        logic [31:0] d;
        logic [1:0]  r;
        bit ok, held;
        int n, ts0, cs0, tf0;
        calculate_finish = 1;
        ts0 = ts_cnt; cs0 = cs_cnt;
        awaddr = 8'h00; wdata = 32'h1; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        awaddr = 8'h20; wdata = 32'h1357_9BDF;
        held = (n < 20);
        for (int i = 0; i < 5; i++) begin
            if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) held = 0;
            @(negedge clk);
        end
        n_checks++;
        if (!held) begin
            n_fail++;
            $display("FAIL bresp_backpressure: bvalid=%b awready=%b want 1 0", bvalid, awready);
        end
        n_checks++;
        if (ts_cnt - ts0 != 1 || cs_cnt != cs0) begin
            n_fail++;
            $display("FAIL task_start_pulse: ts=%0d cs=%0d want 1 0", ts_cnt - ts0, cs_cnt - cs0);
        end
        bready = 1;
        @(negedge clk);
        bready = 0;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        while (!bvalid && n < 40) begin @(negedge clk); n++; end
        bready = 1;
        @(negedge clk);
        bready = 0;
        n_checks++;
        if (n >= 20 || ret_addr !== 32'h1357_9BDF) begin
            n_fail++;
            $display("FAIL queued_write: ret_addr=%h want 13579bdf", ret_addr);
        end
        axi_read(8'h04, d, r, ok);
        n_checks++;
        if (!ok || d !== 32'h2) begin
            n_fail++;
            $display("FAIL status_after_task: rdata=%h want 2", d);
        end
        tf0 = tf_cnt;
        axi_write(8'h00, 32'h6, 4'hF, r, ok);
        repeat (3) @(negedge clk);
        axi_read(8'h04, d, r, ok);
        n_checks++;
        if (!ok || d !== 32'h2 || cs_cnt - cs0 != 1 || tf_cnt - tf0 != 1) begin
            n_fail++;
            $display("FAIL start_finish_tied: status=%h cs=%0d tf=%0d want 2 1 1",
                     d, cs_cnt - cs0, tf_cnt - tf0);
        end
        calculate_finish = 0;
    endtask

    task automatic test_read_hold;
        logic [1:0] r;
        bit ok, held;
        int n;
        araddr = 8'h04; arvalid = 1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 0;
        axi_write(8'h00, 32'h2, 4'hF, r, ok);
        n_checks++;
        if (n >= 20 || !ok || rvalid !== 1'b1 || rdata !== 32'h2) begin
            n_fail++;
            $display("FAIL status_hold: rvalid=%b rdata=%h want 1 00000002", rvalid, rdata);
        end
        rready = 1;
        @(negedge clk);
        rready = 0;
        araddr = 8'hFC; arvalid = 1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 0;
        held = (n < 20);
        for (int i = 0; i < 3; i++) begin
            if (rvalid !== 1'b1 || rdata !== 32'h0 || rresp !== 2'b00) held = 0;
            @(negedge clk);
        end
        n_checks++;
        if (!held) begin
            n_fail++;
            $display("FAIL unmapped_read_hold: rvalid=%b rdata=%h rresp=%b want 1 0 00",
                     rvalid, rdata, rresp);
        end
        rready = 1;
        @(negedge clk);
        rready = 0;
        n_checks++;
        if (rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rvalid_clear: rvalid=%b want 0", rvalid);
        end
        araddr = 8'h04; arvalid = 1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 0;
        n_checks++;
        if (n >= 20 || rvalid !== 1'b1 || rdata !== 32'h1) begin
            n_fail++;
            $display("FAIL status_rebusy: rdata=%h want 00000001", rdata);
        end
        rready = 1;
        @(negedge clk);
        rready = 0;
    endtask

    initial begin
        test_reset;
        test_strobe;
        test_ctrl;
        test_params;
        test_calc;
        test_finish_tied;
        test_read_hold;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
